// File: rtl/mips_avalon_arbiter.sv
// Multiplexes N requester ports onto one Avalon-MM master, one transaction at a time.
// Grant in IDLE, hold the command through waitrequest in BUS, one-cycle ack in ACK.
module mips_avalon_arbiter #(
    parameter int  N_PORTS = 2,
    parameter int  ADDR_W  = 32,
    parameter int  DATA_W  = 32,
    parameter int  RR_MODE = 1,
    localparam int BE_W    = DATA_W / 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_PORTS-1:0]          req,
    input  logic [N_PORTS-1:0]          req_we,
    input  logic [N_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [N_PORTS*DATA_W-1:0]   req_wdata,
    input  logic [N_PORTS*BE_W-1:0]     req_be,
    output logic [N_PORTS-1:0]          ack,
    output logic [DATA_W-1:0]           rdata,
    output logic                        busy,
    output logic [ADDR_W-1:0]           address,
    output logic                        write,
    output logic                        read,
    input  logic                        waitrequest,
    output logic [DATA_W-1:0]           writedata,
    output logic [BE_W-1:0]             byteenable,
    input  logic [DATA_W-1:0]           readdata
);

    localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t              state_q,      state_d;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d;
    logic [N_PORTS-1:0]  ack_q,        ack_d;
    logic [DATA_W-1:0]   rdata_q,      rdata_d;
    logic                busy_q,       busy_d;
    logic [ADDR_W-1:0]   address_q,    address_d;
    logic                write_q,      write_d;
    logic                read_q,       read_d;
    logic [DATA_W-1:0]   writedata_q,  writedata_d;
    logic [BE_W-1:0]     byteenable_q, byteenable_d;

    logic [IDX_W-1:0]    grant_sel;
    logic                grant_found;
    int                  rr_cand;

    // Round-robin searches upward from the port after the last grant, wrapping past N_PORTS-1.
    always_comb begin
        grant_sel   = '0;
        grant_found = 1'b0;
        rr_cand     = 0;
        if (RR_MODE != 0) begin
            for (int off = 1; off <= N_PORTS; off++) begin
                rr_cand = int'(last_grant_q) + off;
                if (rr_cand >= N_PORTS) begin
                    rr_cand = rr_cand - N_PORTS;
                end
                if (!grant_found && req[rr_cand]) begin
                    grant_sel   = IDX_W'(rr_cand);
                    grant_found = 1'b1;
                end
            end
        end else begin
            for (int i = N_PORTS - 1; i >= 0; i--) begin
                if (req[i]) begin
                    grant_sel   = IDX_W'(i);
                    grant_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        ack_d        = ack_q;
        rdata_d      = rdata_q;
        busy_d       = busy_q;
        address_d    = address_q;
        write_d      = write_q;
        read_d       = read_q;
        writedata_d  = writedata_q;
        byteenable_d = byteenable_q;

        case (state_q)
            ST_IDLE: begin
                ack_d = '0;
                if (grant_found) begin
                    last_grant_d = grant_sel;
                    address_d    = req_addr[int'(grant_sel)*ADDR_W +: ADDR_W];
                    writedata_d  = req_wdata[int'(grant_sel)*DATA_W +: DATA_W];
                    byteenable_d = req_be[int'(grant_sel)*BE_W +: BE_W];
                    write_d      = req_we[grant_sel];
                    read_d       = ~req_we[grant_sel];
                    busy_d       = 1'b1;
                    state_d      = ST_BUS;
                end
            end
            ST_BUS: begin
                if (!waitrequest) begin
                    if (read_q) begin
                        rdata_d = readdata;
                    end
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    for (int i = 0; i < N_PORTS; i++) begin
                        ack_d[i] = (last_grant_q == IDX_W'(i));
                    end
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                // Requests are deliberately not sampled here so an acked port cannot re-issue at once.
                ack_d   = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                ack_d   = '0;
                busy_d  = 1'b0;
                read_d  = 1'b0;
                write_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDX_W'(N_PORTS - 1);
            ack_q        <= '0;
            rdata_q      <= '0;
            busy_q       <= 1'b0;
            address_q    <= '0;
            write_q      <= 1'b0;
            read_q       <= 1'b0;
            writedata_q  <= '0;
            byteenable_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
            busy_q       <= busy_d;
            address_q    <= address_d;
            write_q      <= write_d;
            read_q       <= read_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
        end
    end

    assign ack        = ack_q;
    assign rdata      = rdata_q;
    assign busy       = busy_q;
    assign address    = address_q;
    assign write      = write_q;
    assign read       = read_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Directed bench: a 2-port round-robin arbiter for the protocol cases, plus 4-port
// round-robin and fixed-priority instances for wrap-around and starvation cases.
module tb_mips_avalon_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ---- 2-port round-robin instance ----
    logic [1:0]  req2 = '0, we2 = '0, ack2;
    logic [63:0] addr2 = '0, wdat2 = '0;
    logic [7:0]  be2 = '0;
    logic [31:0] rdata2, address2, writedata2, rddata2 = '0;
    logic        busy2, write2, read2, wait2 = 1'b0;
    logic [3:0]  byteenable2;

    mips_avalon_arbiter #(.N_PORTS(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(1)) u_dut2 (
        .clk(clk), .reset(reset), .req(req2), .req_we(we2), .req_addr(addr2),
        .req_wdata(wdat2), .req_be(be2), .ack(ack2), .rdata(rdata2), .busy(busy2),
        .address(address2), .write(write2), .read(read2), .waitrequest(wait2),
        .writedata(writedata2), .byteenable(byteenable2), .readdata(rddata2)
    );

    // ---- 4-port round-robin instance ----
    logic [3:0]   req4 = '0, ack4, be_o4;
    logic [127:0] addr4 = '0, wdat4 = '0;
    logic [15:0]  be4 = '0;
    logic [31:0]  rdata4, address4, writedata4;
    logic         busy4, write4, read4;

    mips_avalon_arbiter #(.N_PORTS(4), .ADDR_W(32), .DATA_W(32), .RR_MODE(1)) u_dut4 (
        .clk(clk), .reset(reset), .req(req4), .req_we(4'b0000), .req_addr(addr4),
        .req_wdata(wdat4), .req_be(be4), .ack(ack4), .rdata(rdata4), .busy(busy4),
        .address(address4), .write(write4), .read(read4), .waitrequest(1'b0),
        .writedata(writedata4), .byteenable(be_o4), .readdata(32'h0000_0004)
    );

    // ---- 4-port fixed-priority instance ----
    logic [3:0]   reqf = '0, ackf, be_of;
    logic [31:0]  rdataf, addressf, writedataf;
    logic         busyf, writef, readf;

    mips_avalon_arbiter #(.N_PORTS(4), .ADDR_W(32), .DATA_W(32), .RR_MODE(0)) u_dutf (
        .clk(clk), .reset(reset), .req(reqf), .req_we(4'b0000), .req_addr(addr4),
        .req_wdata(wdat4), .req_be(be4), .ack(ackf), .rdata(rdataf), .busy(busyf),
        .address(addressf), .write(writef), .read(readf), .waitrequest(1'b0),
        .writedata(writedataf), .byteenable(be_of), .readdata(32'h0000_0008)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Index of the single set bit, -1 when none, -2 when more than one.
    function automatic int oh_idx(input logic [3:0] a);
        int idx = -1;
        for (int i = 0; i < 4; i++) begin
            if (a[i]) idx = (idx == -1) ? i : -2;
        end
        return idx;
    endfunction

    // Results of the most recent run2 call.
    int          r_rd, r_wr, r_ack_edge, r_nack, r_dbl, r_chg, r_ack_addr_bad;
    logic        r_busy_ack, r_seen;
    logic [31:0] r_addr, r_wdat, r_rdata;
    logic [3:0]  r_be;
    int          r_order[$];

    // Runs the 2-port instance until n_acks acks or the cycle budget expires. waitrequest
    // is high on the first wait_n edges after the grant edge.
    task automatic run2(input int wait_n, input int n_acks, input int budget);
        int idx;
        r_rd = 0; r_wr = 0; r_ack_edge = -1; r_nack = 0; r_dbl = 0; r_chg = 0;
        r_ack_addr_bad = 0; r_busy_ack = 1'b0; r_seen = 1'b0; r_rdata = '0;
        r_addr = '0; r_wdat = '0; r_be = '0;
        r_order.delete();
        wait2 = (wait_n > 0);
        for (int i = 0; i < budget && r_nack < n_acks; i++) begin
            tick();
            if (read2) r_rd++;
            if (write2) r_wr++;
            if (read2 || write2) begin
                if (!r_seen) begin
                    r_seen = 1'b1;
                    r_addr = address2; r_wdat = writedata2; r_be = byteenable2;
                end else if (address2 != r_addr || writedata2 != r_wdat || byteenable2 != r_be) begin
                    r_chg++;
                end
            end
            idx = oh_idx({2'b00, ack2});
            if (idx == -2) r_dbl++;
            else if (idx >= 0) begin
                r_order.push_back(idx);
                r_nack++;
                if (address2 != addr2[idx*32 +: 32]) r_ack_addr_bad++;
                if (r_nack == 1) begin
                    r_ack_edge = i; r_rdata = rdata2; r_busy_ack = busy2;
                end
                r_seen = 1'b0;
            end
            wait2 = (i + 1 < wait_n + 1) && (i + 1 <= wait_n);
            rddata2 = wait2 ? 32'hBAD0_0000 : 32'hDEADBEEF;
        end
    endtask

    initial begin
        int order4[$];
        int idx, dbl, fp0, fp2, fpn;

        repeat (3) tick();
        check("rst_ack",        ack2,        0);
        check("rst_rdata",      rdata2,      0);
        check("rst_busy",       busy2,       0);
        check("rst_address",    address2,    0);
        check("rst_write",      write2,      0);
        check("rst_read",       read2,       0);
        check("rst_writedata",  writedata2,  0);
        check("rst_byteenable", byteenable2, 0);
        reset = 1'b0;
        tick();

        // Read on port 0 with two wait states; port 1 fields are decoys.
        addr2 = {32'h0000_1004, 32'h0000_0040};
        wdat2 = {32'h1234_5678, 32'hCAFE_F00D};
        be2   = {4'b0011, 4'b1111};
        we2   = 2'b10;
        req2  = 2'b01;
        rddata2 = 32'hBAD0_0000;
        run2(2, 1, 12);
        req2 = 2'b00;
        check("rd_read_cycles",  r_rd, 3);
        check("rd_write_cycles", r_wr, 0);
        check("rd_cmd_stable",   r_chg, 0);
        check("rd_address",      r_addr, 32'h0000_0040);
        check("rd_ack_port",     (r_order.size() > 0) ? r_order[0] : -1, 0);
        check("rd_ack_edge",     r_ack_edge, 3);
        check("rd_rdata",        r_rdata, 32'hDEADBEEF);
        check("rd_busy_on_ack",  r_busy_ack, 1);
        tick();
        check("rd_ack_clears",   ack2, 0);
        check("rd_busy_clears",  busy2, 0);
        check("rd_rdata_holds",  rdata2, 32'hDEADBEEF);
        tick();

        // Zero-wait write on port 1 with a partial byte enable.
        req2 = 2'b10;
        rddata2 = 32'h5555_5555;
        run2(0, 1, 12);
        req2 = 2'b00;
        check("wr_write_cycles", r_wr, 1);
        check("wr_read_cycles",  r_rd, 0);
        check("wr_address",      r_addr, 32'h0000_1004);
        check("wr_writedata",    r_wdat, 32'h1234_5678);
        check("wr_byteenable",   r_be, 4'b0011);
        check("wr_ack_port",     (r_order.size() > 0) ? r_order[0] : -1, 1);
        check("wr_ack_edge",     r_ack_edge, 1);
        check("wr_rdata_kept",   r_rdata, 32'hDEADBEEF);
        repeat (2) tick();

        // Both ports held: last grant was port 1, so alternation starts at port 0.
        we2  = 2'b00;
        req2 = 2'b11;
        run2(0, 6, 40);
        req2 = 2'b00;
        check("rr2_count", r_order.size(), 6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("rr2_grant%0d", k), (r_order.size() > k) ? r_order[k] : -1, k % 2);
        end
        check("rr2_double_ack", r_dbl, 0);
        check("rr2_ack_address", r_ack_addr_bad, 0);
        repeat (2) tick();

        // 4-port round-robin from reset (last grant 3), ports 0 and 3 requesting.
        addr4 = {32'h30, 32'h20, 32'h10, 32'h00};
        req4  = 4'b1001;
        dbl   = 0;
        for (int i = 0; i < 40 && order4.size() < 3; i++) begin
            tick();
            idx = oh_idx(ack4);
            if (idx == -2) dbl++;
            else if (idx >= 0) order4.push_back(idx);
        end
        req4 = 4'b0000;
        check("rr4_grant0", (order4.size() > 0) ? order4[0] : -1, 0);
        check("rr4_grant1", (order4.size() > 1) ? order4[1] : -1, 3);
        check("rr4_grant2", (order4.size() > 2) ? order4[2] : -1, 0);
        check("rr4_double_ack", dbl, 0);

        // Fixed priority: port 0 starves port 2 for five transactions.
        reqf = 4'b0101;
        fp0 = 0; fp2 = 0; fpn = 0;
        for (int i = 0; i < 40 && fpn < 5; i++) begin
            tick();
            if (ackf != 0) fpn++;
            if (ackf[0]) fp0++;
            if (ackf[2]) fp2++;
        end
        reqf = 4'b0000;
        check("fp_port0_acks", fp0, 5);
        check("fp_port2_acks", fp2, 0);
        repeat (2) tick();

        // Reset mid-BUS with waitrequest high; port 0 was last granted before the reset.
        req2 = 2'b01;
        wait2 = 1'b1;
        tick();
        tick();
        check("rs_read_before", read2, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rs_read",    read2, 0);
        check("rs_write",   write2, 0);
        check("rs_busy",    busy2, 0);
        check("rs_ack",     ack2, 0);
        check("rs_address", address2, 0);
        req2 = 2'b11;
        run2(0, 1, 12);
        req2 = 2'b00;
        check("rs_first_grant", (r_order.size() > 0) ? r_order[0] : -1, 0);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
